// File: rtl/bin_search_pkg.sv
// Shared types and default sizes for the binary-search datapath and its helpers.
package bin_search_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_t;

    function automatic cmp_t compare_words(input logic [63:0] data, input logic [63:0] ref_value);
        if (data == ref_value) begin
            return CMP_EQ;
        end else if (data < ref_value) begin
            return CMP_LT;
        end
        return CMP_GT;
    endfunction

endpackage

// File: rtl/bin_search_mid.sv
// Combinational next-window calculator: narrows low/high around the probed mid
// and flags exhaustion before any bound would step outside the address range.
module bin_search_mid
    import bin_search_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] low,
    input  logic [ADDR_W-1:0] high,
    input  logic [ADDR_W-1:0] mid,
    input  cmp_t              cmp,
    output logic [ADDR_W-1:0] new_low,
    output logic [ADDR_W-1:0] new_high,
    output logic [ADDR_W-1:0] new_mid,
    output logic              exhausted
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    // Exhaustion is decided on the old bounds, so the wrapped mid+1 / mid-1
    // values are never committed when the window would collapse past an edge.
    always_comb begin
        new_low   = low;
        new_high  = high;
        exhausted = 1'b0;
        unique case (cmp)
            CMP_LT: begin
                exhausted = (mid == high);
                new_low   = mid + ONE;
            end
            CMP_GT: begin
                exhausted = (mid == low);
                new_high  = mid - ONE;
            end
            default: begin
                new_low  = low;
                new_high = high;
            end
        endcase
    end

    // low<=high holds whenever the result is used, so the difference never wraps.
    always_comb begin
        new_mid = new_low + ((new_high - new_low) >> 1);
    end

endmodule

// File: rtl/bin_search_datapath.sv
// Binary-search datapath: owns the search window, addresses the sorted RAM and
// reports the outcome back to the strobe-driven control FSM.
module bin_search_datapath
    import bin_search_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              hold,
    input  logic              comp,
    input  logic [DATA_W-1:0] target,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              finish,
    output logic              found,
    output logic [ADDR_W-1:0] loc,
    output logic [ADDR_W-1:0] iter
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] INIT_MID = ADDR_MAX >> 1;
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    logic [ADDR_W-1:0] low;
    logic [ADDR_W-1:0] high;
    logic [ADDR_W-1:0] mid;
    logic [DATA_W-1:0] target_q;

    cmp_t              cmp;
    logic [ADDR_W-1:0] new_low;
    logic [ADDR_W-1:0] new_high;
    logic [ADDR_W-1:0] new_mid;
    logic              exhausted;

    always_comb begin
        cmp = compare_words(64'(ram_rdata), 64'(target_q));
    end

    bin_search_mid #(
        .ADDR_W(ADDR_W)
    ) u_mid (
        .low      (low),
        .high     (high),
        .mid      (mid),
        .cmp      (cmp),
        .new_low  (new_low),
        .new_high (new_high),
        .new_mid  (new_mid),
        .exhausted(exhausted)
    );

    // Reset and clear share the window initialisation; only clear samples target.
    always_ff @(posedge clk) begin
        if (reset) begin
            low      <= '0;
            high     <= ADDR_MAX;
            mid      <= INIT_MID;
            finish   <= 1'b0;
            found    <= 1'b0;
            loc      <= '0;
            iter     <= '0;
            target_q <= '0;
        end else if (clear) begin
            low      <= '0;
            high     <= ADDR_MAX;
            mid      <= INIT_MID;
            finish   <= 1'b0;
            found    <= 1'b0;
            loc      <= '0;
            iter     <= '0;
            target_q <= target;
        end else if (comp && !finish) begin
            iter <= iter + ONE;
            if (cmp == CMP_EQ) begin
                found  <= 1'b1;
                finish <= 1'b1;
                loc    <= mid;
            end else if (exhausted) begin
                finish <= 1'b1;
                found  <= 1'b0;
            end else begin
                low  <= new_low;
                high <= new_high;
                mid  <= new_mid;
            end
        end else if (hold) begin
            // RAM read of the current mid is in flight; the window stays frozen.
            low <= low;
        end
    end

    assign ram_addr = mid;

endmodule

// File: tb/tb_bin_search_datapath.sv
// Self-checking bench: sorted RAM model, negedge strobe controller and a
// plain binary-search reference model checked against the DUT every cycle.
module tb_bin_search_datapath;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              hold;
    logic              comp;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              finish;
    logic              found;
    logic [ADDR_W-1:0] loc;
    logic [ADDR_W-1:0] iter;

    logic [DATA_W-1:0] ram [DEPTH];

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    int exp_addr, exp_finish, exp_found, exp_loc, exp_iter;

    int probes [16];
    int nprobes;
    int m_found;
    int m_loc;

    always #5 clk = ~clk;

    bin_search_datapath #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .hold     (hold),
        .comp     (comp),
        .target   (target),
        .ram_rdata(ram_rdata),
        .ram_addr (ram_addr),
        .finish   (finish),
        .found    (found),
        .loc      (loc),
        .iter     (iter)
    );

    // Synchronous-read RAM, one cycle of latency.
    always @(posedge clk) begin
        ram_rdata <= ram[ram_addr];
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (checking) begin
            check("ram_addr", int'(ram_addr), exp_addr);
            check("finish", int'(finish), exp_finish);
            check("found", int'(found), exp_found);
            check("loc", int'(loc), exp_loc);
            check("iter", int'(iter), exp_iter);
        end
    end

    // Textbook binary search over the RAM contents with unbounded integers.
    task automatic model_search(input int tgt);
        int lo, hi, m;
        lo = 0;
        hi = DEPTH - 1;
        nprobes = 0;
        m_found = 0;
        m_loc = 0;
        while (lo <= hi) begin
            m = (lo + hi) / 2;
            probes[nprobes] = m;
            nprobes++;
            if (int'(ram[m]) == tgt) begin
                m_found = 1;
                m_loc = m;
                break;
            end else if (int'(ram[m]) < tgt) begin
                lo = m + 1;
            end else begin
                hi = m - 1;
            end
        end
    endtask

    task automatic expect_init();
        exp_addr   = (DEPTH - 1) >> 1;
        exp_finish = 0;
        exp_found  = 0;
        exp_loc    = 0;
        exp_iter   = 0;
    endtask

    task automatic drive(input logic r, input logic c, input logic h, input logic p);
        @(negedge clk);
        reset = r;
        clear = c;
        hold  = h;
        comp  = p;
    endtask

    // Controller: clear (optionally with a colliding comp), then hold/comp pairs.
    task automatic run_search(input int tgt, input int max_comps, input bit comp_on_clear);
        model_search(tgt);
        drive(1'b0, 1'b1, 1'b0, comp_on_clear);
        target = DATA_W'(tgt);
        expect_init();
        for (int k = 1; k <= nprobes && k <= max_comps; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            exp_iter = k;
            if (k < nprobes) begin
                exp_addr = probes[k];
            end else begin
                exp_finish = 1;
                exp_found  = m_found;
                exp_loc    = m_found ? m_loc : 0;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = DATA_W'(2 * i);
        end
        reset  = 1'b1;
        clear  = 1'b0;
        hold   = 1'b0;
        comp   = 1'b0;
        target = '0;
        expect_init();
        checking = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Pin the reference model against hand-derived probe sequences.
        model_search(20);
        check("model20_len", nprobes, 5);
        check("model20_p1", probes[1], 7);
        check("model20_p2", probes[2], 11);
        check("model20_p3", probes[3], 9);
        check("model20_p4", probes[4], 10);
        model_search(63);
        check("model63_len", nprobes, 6);
        check("model63_p5", probes[5], 31);
        check("model63_found", m_found, 0);

        run_search(20, 99, 1'b0);
        settle();
        check("t20_loc", int'(loc), 10);
        check("t20_iter", int'(iter), 5);
        check("t20_found", int'(found), 1);

        // Comps after finish must leave everything unchanged.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        run_search(21, 99, 1'b0);
        settle();
        check("t21_found", int'(found), 0);
        check("t21_iter", int'(iter), 5);

        run_search(0, 99, 1'b0);
        settle();
        check("t0_loc", int'(loc), 0);
        check("t0_found", int'(found), 1);

        run_search(63, 99, 1'b0);
        settle();
        check("t63_iter", int'(iter), 6);
        check("t63_addr", int'(ram_addr), 31);

        // clear together with comp: clear wins and the new search proceeds.
        run_search(5, 99, 1'b1);
        settle();
        check("t5_found", int'(found), 0);

        // Reset in the middle of a search, then a fresh search to the top word.
        run_search(20, 2, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_init();
        settle();
        check("midreset_addr", int'(ram_addr), 15);
        check("midreset_iter", int'(iter), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        run_search(62, 99, 1'b0);
        settle();
        check("t62_loc", int'(loc), 31);
        check("t62_found", int'(found), 1);

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_search_datapath.md
Name: bin_search_datapath

Overview:
- Datapath for the binary search of a sorted, synchronous-read RAM.
- Driven by the search control FSM through its clear/hold/comp strobes; returns finish to it.
- Owns the low/high/mid search window, drives the RAM read address and compares read data to the latched target.
- Reports found/not-found, the matching location and the number of compare steps used.

Parameters:
- ADDR_W, 5, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM word / target width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  re-initialise the search window and sample the target.
- hold  input  1  stall cycle; RAM read of ram_addr is in flight.
- comp  input  1  execute one compare/narrow step on ram_rdata.
- target  input  DATA_W  value searched for; sampled only while clear=1.
- ram_rdata  input  DATA_W  RAM read data; one-cycle latency from ram_addr.
- ram_addr  output  ADDR_W  RAM read address (the current mid).
- finish  output  1  search complete (sticky until clear/reset).
- found  output  1  target located (valid when finish=1).
- loc  output  ADDR_W  matching address (valid when found=1, else 0).
- iter  output  ADDR_W  count of compare steps executed since the last clear.

Behaviour:
- Clock and reset:
  - reset: reset, synchronous, active-high; clock: clk. All registers update on posedge clk.
  - Control strobes come from a negedge-clocked controller and are stable at posedge.
- Reset and clear (identical effect, except reset also zeroes target_q):
  - low=0, high=2**ADDR_W-1, ram_addr=(2**ADDR_W-1)>>1 (15 for ADDR_W=5).
  - finish=0, found=0, loc=0, iter=0.
  - clear additionally latches target_q=target.
- Priority: reset > clear > comp > hold. With clear=1 and comp=1 together, clear wins and comp is ignored.
- hold, or no strobe asserted: all registers keep their value.
- comp while finish=0: iter+=1, then compare ram_rdata with target_q:
  - equal: found=1, finish=1, loc=ram_addr.
  - ram_rdata < target_q:
    - if ram_addr==high: finish=1, found=0 (exhausted).
    - else low=ram_addr+1.
  - ram_rdata > target_q:
    - if ram_addr==low: finish=1, found=0 (exhausted).
    - else high=ram_addr-1.
  - When not finished, the new ram_addr = new_low + ((new_high-new_low)>>1), registered in the same cycle.
- comp while finish=1: ignored; no register changes, iter frozen.
- Width rules:
  - Invariant low<=high holds while active, so the mid computation never needs extra bits.
  - The exhaustion checks prevent high underflow at 0 and low overflow at 2**ADDR_W-1.
- Step bound: at most ADDR_W+1 compare steps per search; iter never wraps.
- Timing: finish, found and loc are visible the cycle after the deciding comp posedge.
- Controller cadence is clear, then alternating hold/comp. A comp must be preceded by at least one hold after every ram_addr change; the datapath does not check this.
- The RAM contents are assumed sorted ascending. Behaviour on unsorted contents: terminates within ADDR_W+1 steps; result undefined.

Decomposition:
- Shared package bin_search_pkg:
  - compare-result enum {CMP_LT, CMP_EQ, CMP_GT}.
  - default ADDR_W/DATA_W constants.
- One natural sub-module: bin_search_mid, a combinational mid/next-window calculator (low, high, cmp -> new_low, new_high, new_mid, exhausted).
- Bench instantiates bin_search_datapath with a 32x8 synchronous RAM model and the search control FSM.

Test Plan:
- RAM[i]=2*i, target=20, full clear/hold/comp cadence -> ram_addr sequence 15,7,11,9,10; finish=1, found=1, loc=10, iter=5.
- Same RAM, target=21 -> final window low=high=10, 20<21 -> finish=1, found=0, loc=0, iter=5.
- Same RAM, target=0 -> ram_addr 15,7,3,1,0; found=1, loc=0, iter=5; no high underflow.
- Same RAM, target=63 -> ram_addr 15,23,27,29,30,31; finish=1, found=0, iter=6; no low overflow.
- Extra comp pulses after finish -> outputs unchanged. clear+comp in the same cycle -> window re-initialised, ram_addr=15, iter=0.
- reset asserted mid-search (after 2 comps, target=20) -> next cycle ram_addr=15, finish=0, iter=0. A subsequent search for target=62 -> found=1, loc=31.
